// File: rtl/alu_if.sv
// Request/completion bundle between the issue stage and alu_exec.
// start is accepted only while busy is low; wb_en is a one-cycle completion strobe with no back-pressure.
interface alu_if;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  dst_sel;
  logic [31:0] result;
  logic [3:0]  wb_addr;
  logic        wb_en;
  logic        busy;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        err;
  logic [2:0]  dbg_state;

  modport master (
    output start, opcode, op_a, op_b, dst_sel,
    input  result, wb_addr, wb_en, busy, zero, carry, overflow, err, dbg_state
  );

  modport slave (
    input  start, opcode, op_a, op_b, dst_sel,
    output result, wb_addr, wb_en, busy, zero, carry, overflow, err, dbg_state
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: single-cycle ALU ops, 32-step shift-add multiply and,
// when ALU_DIV_EN is defined, a 32-step restoring divider (DIVU/REMU); otherwise those opcodes are illegal.
module alu_exec (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_REMU = 4'hC;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  dst_q, dst_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic        wb_en_q, wb_en_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic        iter_done;
  logic [32:0] sum33;
  logic [32:0] dif33;
  logic [31:0] alu_res;
  logic        alu_carry;
  logic        alu_ovf;
  logic        alu_legal;

  // Multiply uses a_q as the left-shifting multiplicand and b_q as the right-shifting multiplier;
  // divide shifts the dividend out of a_q while quotient bits shift in, with the remainder in acc_q.
  assign iter_done = (cnt_q == 6'd32);

`ifdef ALU_DIV_EN
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] div_res;

  assign div_shift = {acc_q, a_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift[31:0] - b_q;
  // A zero divisor naturally yields all-ones quotient and remainder equal to the dividend.
  assign div_res   = (opcode_q == OP_DIVU) ? a_q : acc_q;
`endif

  always_comb begin
    sum33     = {1'b0, a_q} + {1'b0, b_q};
    dif33     = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_legal = 1'b1;
    case (opcode_q)
      OP_ADD: begin
        alu_res   = sum33[31:0];
        alu_carry = sum33[32];
        alu_ovf   = (a_q[31] == b_q[31]) && (sum33[31] != a_q[31]);
      end
      OP_SUB: begin
        alu_res   = dif33[31:0];
        alu_carry = dif33[32];
        alu_ovf   = (a_q[31] != b_q[31]) && (dif33[31] != a_q[31]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[4:0];
      OP_SRL:  alu_res = a_q >> b_q[4:0];
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[4:0]);
      OP_SLT:  alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {31'b0, (a_q < b_q)};
      default: alu_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.opcode == OP_MUL) state_d = S_MUL;
`ifdef ALU_DIV_EN
          else if (bus.opcode == OP_DIVU || bus.opcode == OP_REMU) state_d = S_DIV;
`endif
          else state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (iter_done) state_d = S_DONE;
`ifdef ALU_DIV_EN
      S_DIV:  if (iter_done) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    opcode_d  = opcode_q;
    dst_d     = dst_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = 1'b0;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opcode_d = bus.opcode;
          dst_d    = bus.dst_sel;
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_EXEC: begin
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
        if (alu_legal) begin
          result_d  = alu_res;
          zero_d    = (alu_res == 32'd0);
          wb_addr_d = dst_q;
          wb_en_d   = 1'b1;
          err_d     = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_MUL: begin
        if (iter_done) begin
          result_d  = acc_q;
          zero_d    = (acc_q == 32'd0);
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          wb_addr_d = dst_q;
          wb_en_d   = 1'b1;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 6'd1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        if (iter_done) begin
          result_d  = div_res;
          zero_d    = (div_res == 32'd0);
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          err_d     = (b_q == 32'd0);
          wb_addr_d = dst_q;
          wb_en_d   = 1'b1;
        end else begin
          acc_d = div_ge ? div_diff : div_shift[31:0];
          a_d   = {a_q[30:0], div_ge};
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      dst_q     <= dst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule
